rs_msg_extractor: RTL and testbench

Downstream stage of the RS decoder. Consumes the decoder's corrected-codeword stream (n symbols, start/end markers, per-codeword error flag) and strips the n-k parity symbols. Buffers the k message symbols in a small FIFO and re-frames them with message start/end markers for the sink. Provides the backpressure that drives the decoder's i_consume.

---
 rtl/rs_codec_pkg.sv | 45 ++++
 rtl/rs_sym_fifo.sv | 67 ++++++
 rtl/rs_msg_extractor.sv | 193 +++++++++++++++++++
 tb/tb_rs_msg_extractor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_codec_pkg.sv
// Shared types for the RS message extractor: FSM state, FIFO entry tags, width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rs_codec_pkg;

  // Default geometry of the RS(15,11) decoder this stage normally follows
  localparam int unsigned RS_SYM_W_DEF = 8;
  localparam int unsigned RS_N_DEF     = 15;
  localparam int unsigned RS_K_DEF     = 11;
  localparam int unsigned RS_DEPTH_DEF = 16;

  // Position counter width: enough to index every beat of a codeword
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // FIFO pointer / occupancy width: one extra bit so occupancy can reach DEPTH
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned RS_IDX_W = idx_width(RS_N_DEF);
  localparam int unsigned RS_PTR_W = ptr_width(RS_DEPTH_DEF);

  // Codeword framing state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } rs_state_t;

  // Per-symbol framing tags carried alongside each buffered message symbol
  typedef struct packed {
    logic sop;
    logic eom;
    logic err;
  } rs_tag_t;

  // FIFO entry at the default symbol width
  typedef struct packed {
    rs_tag_t                 tag;
    logic [RS_SYM_W_DEF-1:0] sym;
  } rs_entry_t;

endpackage

// File: rtl/rs_sym_fifo.sv
// First-word-fall-through FIFO: head entry is visible on pop_dat whenever !empty.
// Latency: 1 cycle from push to visible head; occupancy is registered.
// Backpressure: full blocks pushes (a same-cycle pop does not free a slot).
module rs_sym_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so the low bits index storage directly
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rs_msg_extractor.sv
// Strips the n-k parity symbols from corrected codewords and re-frames the k message symbols.
// Latency: 1 cycle input-to-output through a FWFT FIFO of DEPTH entries.
// Backpressure: o_in_ready = !full for beats that are buffered; parity/discarded beats always accepted.
// Optional build macro RS_MSG_DROP_ERR_EN: drop whole codewords whose start beat flags an error.
module rs_msg_extractor
  import rs_codec_pkg::*;
#(
  parameter int word_length = 8,
  parameter int n           = 15,
  parameter int k           = 11,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start_codeword,
  input  logic                   i_end_codeword,
  input  logic                   i_error,
  input  logic                   i_valid,
  input  logic [word_length-1:0] i_symbol,
  output logic                   o_in_ready,
  output logic                   o_start_message,
  output logic                   o_end_message,
  output logic                   o_error,
  output logic                   o_valid,
  output logic [word_length-1:0] o_symbol,
  input  logic                   i_consume,
  output logic                   o_frame_err
);

  localparam int IDX_W = int'(idx_width(n));

  localparam logic [IDX_W-1:0] LAST_MSG  = IDX_W'(k - 1);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(n - 1);

  typedef struct packed {
    rs_tag_t                tag;
    logic [word_length-1:0] sym;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

`ifdef RS_MSG_DROP_ERR_EN
  // Errored codewords never reach the sink, so the error tag is never raised
  localparam logic ERR_FWD = 1'b0;
  logic drop_start;
  assign drop_start = i_error;
`else
  localparam logic ERR_FWD = 1'b1;
  logic drop_start;
  assign drop_start = 1'b0;
`endif

  rs_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;
  logic             ferr_q, ferr_d;

  logic             beat;
  logic             will_write;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  entry_t           push_dat;
  entry_t           head_dat;

  assign beat = i_valid && o_in_ready;
  assign push = beat && will_write;
  assign pop  = o_valid && i_consume;

  // FSM state register plus the per-codeword error/drop flags and the frame-error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next state: a start beat always (re)opens a codeword; ends and overruns fall back to IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    drop_d  = drop_q;
    if (beat) begin
      if (i_start_codeword) begin
        idx_d  = IDX_W'(1);
        err_d  = i_error;
        drop_d = drop_start;
        if (i_end_codeword) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (k == 1) begin
          state_d = PAR;
        end else begin
          state_d = MSG;
        end
      end else begin
        case (state_q)
          MSG: begin
            idx_d = idx_q + 1'b1;
            if (i_end_codeword) begin
              state_d = IDLE;
              idx_d   = '0;
            end else if (idx_q == LAST_MSG) begin
              state_d = PAR;
            end
          end
          PAR: begin
            idx_d = idx_q + 1'b1;
            if (i_end_codeword || (idx_q == LAST_BEAT)) begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // Outputs of the FSM: what gets buffered, how it is tagged, and whether framing was violated
  always_comb begin
    will_write       = 1'b0;
    push_dat.tag.sop = 1'b0;
    push_dat.tag.eom = 1'b0;
    push_dat.tag.err = 1'b0;
    push_dat.sym     = i_symbol;
    ferr_d           = 1'b0;
    if (i_start_codeword) begin
      // An end on the start beat is always early since n >= 2
      will_write       = !drop_start;
      push_dat.tag.sop = 1'b1;
      push_dat.tag.eom = (k == 1) || i_end_codeword;
      push_dat.tag.err = ERR_FWD && (i_error || i_end_codeword);
      ferr_d           = beat && ((state_q != IDLE) || i_end_codeword);
    end else begin
      case (state_q)
        MSG: begin
          // Any end inside the message part is early because k < n
          will_write       = !drop_q;
          push_dat.tag.eom = (idx_q == LAST_MSG) || i_end_codeword;
          push_dat.tag.err = ERR_FWD && (err_q || i_end_codeword);
          ferr_d           = beat && i_end_codeword;
        end
        PAR: begin
          // Violation when the end marker and the last position disagree
          ferr_d = beat && (i_end_codeword != (idx_q == LAST_BEAT));
        end
        default: begin
          ferr_d = beat;
        end
      endcase
    end
  end

  assign o_in_ready = !will_write || !fifo_full;
  assign o_frame_err = ferr_q;

  rs_sym_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head entry drives the sink directly; everything reads as zero while empty
  assign o_valid         = !fifo_empty;
  assign o_start_message = o_valid && head_dat.tag.sop;
  assign o_end_message   = o_valid && head_dat.tag.eom;
  assign o_error         = o_valid && head_dat.tag.err;
  assign o_symbol        = o_valid ? head_dat.sym : '0;

endmodule

// File: tb/tb_rs_msg_extractor.sv
// Directed bench for rs_msg_extractor at n=15, k=11, DEPTH=16, 8-bit symbols.
// Table rows: inputs for one cycle, expected ready before the edge, expected outputs after it.
// Hand sequences cover reset, deep backpressure with drain, and asynchronous reset mid-message.
module tb_rs_msg_extractor;

`ifdef RS_MSG_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       i_start_codeword;
  logic       i_end_codeword;
  logic       i_error;
  logic       i_valid;
  logic [7:0] i_symbol;
  logic       o_in_ready;
  logic       o_start_message;
  logic       o_end_message;
  logic       o_error;
  logic       o_valid;
  logic [7:0] o_symbol;
  logic       i_consume;
  logic       o_frame_err;

  int checks   = 0;
  int failures = 0;

  rs_msg_extractor #(
    .word_length (8),
    .n           (15),
    .k           (11),
    .DEPTH       (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start_codeword (i_start_codeword),
    .i_end_codeword   (i_end_codeword),
    .i_error          (i_error),
    .i_valid          (i_valid),
    .i_symbol         (i_symbol),
    .o_in_ready       (o_in_ready),
    .o_start_message  (o_start_message),
    .o_end_message    (o_end_message),
    .o_error          (o_error),
    .o_valid          (o_valid),
    .o_symbol         (o_symbol),
    .i_consume        (i_consume),
    .o_frame_err      (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld, st, en, er;
    logic [7:0] sym;
    logic       rdy;
    logic       ov, osop, oeop, oerr;
    logic [7:0] osym;
    logic       oferr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic vld, st, en, er, input logic [7:0] sym,
                              input logic rdy, ov, osop, oeop, oerr,
                              input logic [7:0] osym, input logic oferr);
    vec_t v;
    v.vld = vld; v.st = st; v.en = en; v.er = er; v.sym = sym;
    v.rdy = rdy; v.ov = ov; v.osop = osop; v.oeop = oeop; v.oerr = oerr;
    v.osym = osym; v.oferr = oferr;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic reset_dut();
    i_valid = 1'b0; i_start_codeword = 1'b0; i_end_codeword = 1'b0; i_error = 1'b0;
    i_symbol = 8'h00; i_consume = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic st, en, er, input logic [7:0] sym);
    int w;
    w = 0;
    i_valid = 1'b1; i_start_codeword = st; i_end_codeword = en; i_error = er; i_symbol = sym;
    #1;
    while (!o_in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 300) begin
      checks++; failures++;
      $display("FAIL send_timeout[%0h] actual=stalled required=accepted", sym);
    end else begin
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_start_codeword = 1'b0; i_end_codeword = 1'b0; i_error = 1'b0;
  endtask

  logic [7:0] got_sym[$];
  logic       got_sop[$];
  logic       got_eop[$];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ev;
    logic [7:0] s;

    // ---------------- reset state ----------------
    rst = 1'b0;
    i_valid = 1'b0; i_start_codeword = 1'b0; i_end_codeword = 1'b0; i_error = 1'b0;
    i_symbol = 8'h00; i_consume = 1'b1;
    #12;
    chk("rst_valid", 0, o_valid, 0);
    chk("rst_sop", 0, o_start_message, 0);
    chk("rst_eop", 0, o_end_message, 0);
    chk("rst_err", 0, o_error, 0);
    chk("rst_sym", 0, o_symbol, 0);
    chk("rst_ferr", 0, o_frame_err, 0);
    chk("rst_rdy", 0, o_in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- vector table ----------------
    // Clean codeword 1..15: message 1..11 flows through, parity dropped
    for (int b = 0; b < 15; b++) begin
      s = 8'(b + 1);
      add(1, b == 0, b == 14, 0, s, 1, b < 11, b == 0, b == 10, 0, (b < 11) ? s : 8'h00, 0);
    end
    // Early end on the sixth beat: that symbol closes the message flagged as errored
    for (int b = 0; b < 6; b++) begin
      s = 8'(8'h21 + b);
      add(1, b == 0, b == 5, 0, s, 1, 1, b == 0, b == 5, (b == 5) && !DROP, s, b == 5);
    end
    // Uncorrectable codeword: forwarded with error tag, or dropped entirely
    for (int b = 0; b < 15; b++) begin
      s  = 8'(8'h31 + b);
      ev = (b < 11) && !DROP;
      add(1, b == 0, b == 14, 1, s, 1, ev, ev && b == 0, ev && b == 10, ev, ev ? s : 8'h00, 0);
    end
    // Beat without start while idle is discarded
    add(1, 0, 0, 0, 8'h55, 1, 0, 0, 0, 0, 8'h00, 1);
    // Start on the ninth beat restarts the codeword with that symbol
    for (int b = 0; b < 8; b++) begin
      s = 8'(8'h41 + b);
      add(1, b == 0, 0, 0, s, 1, 1, b == 0, 0, 0, s, 0);
    end
    add(1, 1, 0, 0, 8'h49, 1, 1, 1, 0, 0, 8'h49, 1);
    for (int j = 1; j < 15; j++) begin
      s = 8'(8'h49 + j);
      add(1, 0, j == 14, 0, s, 1, j <= 10, 0, j == 10, 0, (j <= 10) ? s : 8'h00, 0);
    end
    // Missing end on the last beat
    for (int b = 0; b < 15; b++) begin
      s = 8'(8'h61 + b);
      add(1, b == 0, 0, 0, s, 1, b < 11, b == 0, b == 10, 0, (b < 11) ? s : 8'h00, b == 14);
    end
    // After the overrun the FSM is idle, so a stray beat is flagged again
    add(1, 0, 0, 0, 8'h77, 1, 0, 0, 0, 0, 8'h00, 1);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      i_valid = tbl[i].vld; i_start_codeword = tbl[i].st; i_end_codeword = tbl[i].en;
      i_error = tbl[i].er; i_symbol = tbl[i].sym; i_consume = 1'b1;
      #1;
      chk("tbl_rdy", i, o_in_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk("tbl_valid", i, o_valid, tbl[i].ov);
      chk("tbl_sop", i, o_start_message, tbl[i].osop);
      chk("tbl_eop", i, o_end_message, tbl[i].oeop);
      chk("tbl_err", i, o_error, tbl[i].oerr);
      chk("tbl_sym", i, o_symbol, tbl[i].osym);
      chk("tbl_ferr", i, o_frame_err, tbl[i].oferr);
    end
    i_valid = 1'b0; i_start_codeword = 1'b0; i_end_codeword = 1'b0; i_error = 1'b0;

    // ---------------- backpressure: three codewords into a 16-deep FIFO ----------------
    reset_dut();
    i_consume = 1'b0;
    for (int b = 0; b < 15; b++) begin
      i_valid = 1; i_start_codeword = (b == 0); i_end_codeword = (b == 14); i_error = 0;
      i_symbol = 8'(8'h10 + b);
      #1;
      chk("bp_rdy_cw1", b, o_in_ready, 1);
      @(posedge clk); #1;
    end
    for (int b = 0; b < 5; b++) begin
      i_valid = 1; i_start_codeword = (b == 0); i_end_codeword = 0; i_error = 0;
      i_symbol = 8'(8'h20 + b);
      #1;
      chk("bp_rdy_cw2", b, o_in_ready, 1);
      @(posedge clk); #1;
    end
    // Seventeenth message beat must stall while the head stays put
    i_valid = 1; i_start_codeword = 0; i_end_codeword = 0; i_symbol = 8'h25;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_stall_rdy", c, o_in_ready, 0);
      chk("bp_stall_valid", c, o_valid, 1);
      chk("bp_stall_head", c, o_symbol, 8'h10);
      chk("bp_stall_sop", c, o_start_message, 1);
      @(posedge clk); #1;
    end
    i_valid = 0;

    fork
      begin
        for (int b = 5; b < 15; b++) send(0, b == 14, 0, 8'(8'h20 + b));
        for (int b = 0; b < 15; b++) send(b == 0, b == 14, 0, 8'(8'h30 + b));
      end
      begin
        int cyc;
        cyc = 0;
        i_consume = 1'b1;
        while (got_sym.size() < 33 && cyc < 600) begin
          @(negedge clk);
          if (o_valid) begin
            got_sym.push_back(o_symbol);
            got_sop.push_back(o_start_message);
            got_eop.push_back(o_end_message);
          end
          cyc++;
        end
      end
    join

    chk("bp_count", 0, got_sym.size(), 33);
    for (int m = 0; m < got_sym.size() && m < 33; m++) begin
      s = 8'(8'h10 * (m / 11 + 1) + (m % 11));
      chk("bp_sym", m, got_sym[m], s);
      chk("bp_frame", m, {got_sop[m], got_eop[m]}, {m % 11 == 0, m % 11 == 10});
    end
    @(negedge clk);
    chk("bp_drained", 0, o_valid, 0);

    // ---------------- asynchronous reset mid-message ----------------
    reset_dut();
    i_consume = 1'b0;
    send(1, 0, 0, 8'hA0);
    for (int b = 1; b < 5; b++) send(0, 0, 0, 8'(8'hA0 + b));
    chk("ar_pre_valid", 0, o_valid, 1);
    chk("ar_pre_head", 0, o_symbol, 8'hA0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 0, o_valid, 0);
    chk("ar_rdy", 0, o_in_ready, 1);
    chk("ar_sym", 0, o_symbol, 0);
    chk("ar_sop", 0, o_start_message, 0);
    @(negedge clk);
    rst = 1'b1;
    i_consume = 1'b1;
    // Idle after reset: a non-start beat is discarded and flagged
    send(0, 0, 0, 8'hB0);
    chk("ar_idle_ferr", 0, o_frame_err, 1);
    chk("ar_idle_valid", 0, o_valid, 0);
    send(1, 0, 0, 8'hB1);
    chk("ar_new_valid", 0, o_valid, 1);
    chk("ar_new_sym", 0, o_symbol, 8'hB1);
    chk("ar_new_sop", 0, o_start_message, 1);
    chk("ar_new_ferr", 0, o_frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
